// File: rtl/coproc_scheduler_pkg.sv
// coproc_scheduler_pkg: shared state encoding and defaults for the coprocessor scheduler
package coproc_scheduler_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADD_CONST = 3;
  typedef enum logic [2:0] {IDLE, SQ1, ADD, SQ3, DONE} state_e;
  typedef logic [DEF_DATA_W-1:0] op_t;
endpackage

// File: rtl/coproc_scheduler_if.sv
// coproc_scheduler_if: requester handshake plus shared add/mul datapath bus
interface coproc_scheduler_if #(
  parameter int N_REQ = 2,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0] req_valid, req_ready, rsp_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0] rsp_data, mul_a, mul_b, mul_result, add_a, add_b, add_result;
  logic busy;
  modport master (
    output req_valid, req_data, mul_result, add_result,
    input req_ready, rsp_valid, rsp_data, busy, mul_a, mul_b, add_a, add_b
  );
  modport slave (
    input req_valid, req_data, mul_result, add_result,
    output req_ready, rsp_valid, rsp_data, busy, mul_a, mul_b, add_a, add_b
  );
endinterface

// File: rtl/coproc_scheduler_rr_arbiter.sv
// coproc_scheduler_rr_arbiter: picks the first set request at or above ptr, wrapping
module coproc_scheduler_rr_arbiter #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int j;
  always_comb begin
    idx_o = '0;
    j = 0;
    // descending scan so the lowest offset from ptr is the last (winning) write
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr_i) + i) % N;
      if (req_i[j[IW-1:0]]) idx_o = j[IW-1:0];
    end
  end
  assign any_o = |req_i;
  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/coproc_scheduler.sv
// coproc_scheduler: round-robin sharing of one adder and one multiplier computing (x*x+C)^2
module coproc_scheduler
  import coproc_scheduler_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADD_CONST = DEF_ADD_CONST
) (
  input logic clk_i,
  input logic rst_i,
  coproc_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic gnt_any;
  logic [DATA_W-1:0] r_x_q, r_x_d, r_mul_q, r_add_q;
  coproc_scheduler_rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i(bus.req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .any_o(gnt_any)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      r_x_q    <= '0;
      r_mul_q  <= '0;
      r_add_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      r_x_q    <= r_x_d;
      r_mul_q  <= bus.mul_result;
      r_add_q  <= bus.add_result;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (gnt_any ? SQ1 : IDLE) :
              (state_q == SQ1)  ? ADD :
              (state_q == ADD)  ? SQ3 :
              (state_q == SQ3)  ? DONE : IDLE;
    owner_d = (state_q == IDLE && gnt_any) ? gnt_idx : owner_q;
    r_x_d = (state_q == IDLE && gnt_any) ? bus.req_data[gnt_idx*DATA_W +: DATA_W] : r_x_q;
    rr_ptr_d = (state_q != DONE) ? rr_ptr_q :
               (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    bus.req_ready = (state_q == IDLE) ? gnt : '0;
    bus.rsp_valid = (state_q == DONE) ? (N_REQ'(1) << owner_q) : '0;
    bus.rsp_data = (state_q == DONE) ? r_mul_q : '0;
    bus.busy = (state_q != IDLE);
    bus.mul_a = (state_q == SQ1) ? r_x_q : (state_q == SQ3) ? r_add_q : '0;
    bus.mul_b = bus.mul_a;
    bus.add_a = (state_q == ADD) ? r_mul_q : '0;
    bus.add_b = (state_q == ADD) ? DATA_W'(ADD_CONST) : '0;
  end
endmodule

// File: tb/tb_coproc_scheduler.sv
// tb_coproc_scheduler: directed vectors against hand-computed (x*x+3)^2 mod 256 results
module tb_coproc_scheduler;
  logic clk = 0;
  logic rst = 1;
  int n_tests = 0;
  int n_fail = 0;
  coproc_scheduler_if #(.N_REQ(2), .DATA_W(8)) bus ();
  coproc_scheduler #(.N_REQ(2), .DATA_W(8), .ADD_CONST(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.mul_result = bus.mul_a * bus.mul_b;
  assign bus.add_result = bus.add_a + bus.add_b;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_grant(input int r);
    int n = 0;
    #1;
    while (!bus.req_ready[r] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", 32'(bus.req_ready), 32'(1 << r));
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask
  task automatic do_req(input int r, input logic [7:0] x, input logic [7:0] exp);
    bus.req_valid[r] = 1'b1;
    bus.req_data[r*8 +: 8] = x;
    wait_grant(r);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("busy_run", 32'(bus.busy), 1);
      check("no_rsp_early", 32'(bus.rsp_valid), 0);
      if (k == 1) check("sq1_mul_a", 32'(bus.mul_a), 32'(x));
      if (k == 2) check("add_b", 32'(bus.add_b), 3);
    end
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1 << r));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp));
    @(negedge clk);
    check("busy_after", 32'(bus.busy), 0);
    check("rsp_clear", 32'(bus.rsp_valid), 0);
  endtask
  initial begin
    logic [1:0] seen;
    bus.req_valid = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_rsp", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_mul", 32'({bus.mul_a, bus.mul_b}), 0);
    check("rst_add", 32'({bus.add_a, bus.add_b}), 0);
    rst = 0;
    do_req(0, 8'd2, 8'd49);
    do_req(1, 8'd5, 8'd16);
    do_req(0, 8'd20, 8'd105);
    // both requesters contend from reset
    rst = 1;
    bus.req_valid = 2'b11;
    bus.req_data = {8'd5, 8'd2};
    @(negedge clk);
    rst = 0;
    #1;
    check("rr_first", 32'(bus.req_ready), 1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (c == 4) begin
        check("rr_rsp0", 32'(bus.rsp_valid), 1);
        check("rr_data0", 32'(bus.rsp_data), 49);
      end
      if (c == 5) begin
        check("rr_second", 32'(bus.req_ready), 2);
        check("rr_rsp_gap", 32'(bus.rsp_valid), 0);
      end
      if (c == 9) begin
        check("rr_rsp1", 32'(bus.rsp_valid), 2);
        check("rr_data1", 32'(bus.rsp_data), 16);
      end
      if (c == 10) begin
        check("rr_third", 32'(bus.req_ready), 1);
        bus.req_valid = 2'b00;
      end
    end
    repeat (2) @(negedge clk);
    check("rr_idle", 32'(bus.busy), 0);
    // reset during SQ3 aborts the request
    bus.req_valid[0] = 1'b1;
    bus.req_data[7:0] = 8'd2;
    wait_grant(0);
    repeat (3) @(negedge clk);
    check("sq3_mul_a", 32'(bus.mul_a), 7);
    rst = 1;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_mul", 32'({bus.mul_a, bus.mul_b}), 0);
    check("abort_rsp", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    rst = 0;
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("abort_no_rsp", 32'(seen), 0);
    do_req(1, 8'd5, 8'd16);
    // one-cycle pulse while busy is never granted
    bus.req_valid[0] = 1'b1;
    bus.req_data[7:0] = 8'd2;
    wait_grant(0);
    @(negedge clk);
    bus.req_valid[1] = 1'b1;
    #1;
    check("busy_no_grant", 32'(bus.req_ready), 0);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("pulse_rsp_data", 32'(bus.rsp_data), 49);
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_mul", 32'({bus.mul_a, bus.mul_b}), 0);
      check("idle_add", 32'({bus.add_a, bus.add_b}), 0);
      check("idle_ready", 32'(bus.req_ready), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
